tdc_decoder: RTL and testbench

TDC_DECODER -- requirements
Module: tdc_decoder

---
 rtl/adpll_pkg.sv | 18 +
 rtl/tdc_decoder_therm_dec.sv | 25 ++
 rtl/tdc_decoder.sv | 123 ++++++++++++
 tb/tb_tdc_decoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// Shared widths, FSM encoding and fractional saturation limit for the ADPLL TDC path.
package adpll_pkg;

  localparam int RC_W_DEF    = 7;
  localparam int PH_W_DEF    = 16;
  localparam int WORD_W_DEF  = 12;
  localparam int STALL_N_DEF = 4;
  localparam int FRAC_W      = 4;

  localparam logic [FRAC_W-1:0] FRAC_SAT = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/tdc_decoder_therm_dec.sv
// Thermometer phase decoder: saturated popcount plus legality (bubble) flag.
// Purely combinational; no handshake.
module therm_dec
  import adpll_pkg::*;
#(
  parameter int PH_W = PH_W_DEF
) (
  input  logic [PH_W-1:0]   phase_i,
  output logic [FRAC_W-1:0] frac_o,
  output logic              bubble_o
);

  int unsigned ones;

  always_comb begin
    ones = 0;
    for (int i = 0; i < PH_W; i++) begin
      ones = ones + 32'(phase_i[i]);
    end
    frac_o = (ones > 32'(FRAC_SAT)) ? FRAC_SAT : FRAC_W'(ones);
    // Legal codes are 0 or 2^k-1, i.e. x & (x+1) == 0 in PH_W-bit arithmetic.
    bubble_o = |(phase_i & (phase_i + PH_W'(1)));
  end

endmodule

// File: rtl/tdc_decoder.sv
// TDC decoder: accumulates ripple-count deltas into an integer phase and appends the thermometer fraction.
// Sample captured at edge N is presented after edge N+2; no backpressure, en=0 flushes in-flight samples.
module tdc_decoder
  import adpll_pkg::*;
#(
  parameter int RC_W    = RC_W_DEF,
  parameter int PH_W    = PH_W_DEF,
  parameter int WORD_W  = WORD_W_DEF,
  parameter int STALL_N = STALL_N_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [RC_W-1:0]   ripple_count,
  input  logic [PH_W-1:0]   phase,
  output logic [WORD_W-1:0] tdc_word,
  output logic              tdc_valid,
  output logic              bubble_err,
  output logic              dco_stall
);

  localparam int ACC_W = WORD_W - FRAC_W;
  localparam int SC_W  = $clog2(STALL_N + 1);

  state_t state_q, state_d;

  logic [RC_W-1:0]   rc_s1_q, rc_prev_q;
  logic [PH_W-1:0]   ph_s1_q;
  logic              s1_vld_q;

  logic [RC_W-1:0]   delta_d, delta_q;
  logic [FRAC_W-1:0] frac_d, frac_q;
  logic              bub_d, bub_q;
  logic              s2_vld_q;

  logic [ACC_W-1:0]  acc_d, acc_q;
  logic [FRAC_W-1:0] frac_out_q;
  logic              out_vld_q, bub_out_q;
  logic [SC_W-1:0]   stall_d, stall_q;
  logic              adv;

  therm_dec #(.PH_W(PH_W)) u_therm_dec (
    .phase_i  (ph_s1_q),
    .frac_o   (frac_d),
    .bubble_o (bub_d)
  );

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = PRIME;
        PRIME:   state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Modular subtraction handles the free-running counter wrap.
  assign delta_d = rc_s1_q - rc_prev_q;
  assign adv     = en && s2_vld_q;

  always_comb begin
    acc_d   = acc_q;
    stall_d = stall_q;
    if (adv) begin
      acc_d = acc_q + ACC_W'(delta_q);
      if (delta_q == '0) begin
        if (stall_q < SC_W'(STALL_N)) stall_d = stall_q + SC_W'(1);
      end else begin
        stall_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rc_s1_q    <= '0;
      ph_s1_q    <= '0;
      s1_vld_q   <= 1'b0;
      rc_prev_q  <= '0;
      delta_q    <= '0;
      frac_q     <= '0;
      bub_q      <= 1'b0;
      s2_vld_q   <= 1'b0;
      acc_q      <= '0;
      frac_out_q <= '0;
      out_vld_q  <= 1'b0;
      bub_out_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q <= state_d;
      if (en) begin
        rc_s1_q <= ripple_count;
        ph_s1_q <= phase;
      end
      // The sample taken on the IDLE->PRIME edge only seeds rc_prev and is never output.
      s1_vld_q <= en && (state_q != IDLE);
      if (en && (state_q != IDLE)) rc_prev_q <= rc_s1_q;
      s2_vld_q <= en && s1_vld_q;
      if (en && s1_vld_q) begin
        delta_q <= delta_d;
        frac_q  <= frac_d;
        bub_q   <= bub_d;
      end
      acc_q     <= acc_d;
      stall_q   <= stall_d;
      out_vld_q <= adv;
      bub_out_q <= adv && bub_q;
      if (adv) frac_out_q <= frac_q;
    end
  end

  assign tdc_word   = {acc_q, frac_out_q};
  assign tdc_valid  = out_vld_q;
  assign bubble_err = bub_out_q;
  assign dco_stall  = (stall_q >= SC_W'(STALL_N));

endmodule

// File: tb/tb_tdc_decoder.sv
// Directed bench for tdc_decoder: expected words are queued at issue time and popped by a monitor on tdc_valid.
module tb_tdc_decoder;

  localparam int RC_W   = 7;
  localparam int PH_W   = 16;
  localparam int WORD_W = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [RC_W-1:0]   rc;
  logic [PH_W-1:0]   ph;
  logic [WORD_W-1:0] tdc_word;
  logic              tdc_valid, bubble_err, dco_stall;

  typedef struct {
    int word;
    int bub;
    int stall;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tdc_decoder #(.RC_W(RC_W), .PH_W(PH_W), .WORD_W(WORD_W), .STALL_N(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .ripple_count (rc),
    .phase        (ph),
    .tdc_word     (tdc_word),
    .tdc_valid    (tdc_valid),
    .bubble_err   (bubble_err),
    .dco_stall    (dco_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One input sample per cycle; 'out' marks samples that must reach tdc_word two edges after capture.
  task automatic step(input int e, input int r, input int p, input int out,
                      input int w, input int b, input int s);
    exp_t x;
    @(negedge clk);
    en = (e != 0);
    rc = RC_W'(r);
    ph = PH_W'(p);
    if (out != 0) begin
      x.word  = w;
      x.bub   = b;
      x.stall = s;
      x.due   = cyc + 3;
      sb.push_back(x);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (tdc_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_valid: tdc_word=0x%0h with nothing expected (cycle %0d)", tdc_word, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("tdc_word", 32'(tdc_word), 32'(mon_e.word));
          chk("bubble_err", 32'(bubble_err), 32'(mon_e.bub));
          chk("dco_stall", 32'(dco_stall), 32'(mon_e.stall));
          chk("latency_cycle", 32'(cyc), 32'(mon_e.due));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL missing_valid: tdc_valid=0, expected word 0x%0h due cycle %0d (cycle %0d)",
                 sb[0].word, sb[0].due, cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    rc    = '0;
    ph    = '0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_word", 32'(tdc_word), 32'h0);
    chk("reset_valid", 32'(tdc_valid), 32'h0);
    chk("reset_bubble", 32'(bubble_err), 32'h0);
    chk("reset_stall", 32'(dco_stall), 32'h0);
    rst_n = 1'b1;

    // en  rc   phase   out word   bub stall
    step(1,   0, 'h00FF, 0, 'h000, 0, 0);  // IDLE->PRIME edge, seeds rc_prev
    step(1,   3, 'h00FF, 1, 'h038, 0, 0);
    step(1,   6, 'h00FF, 1, 'h068, 0, 0);
    step(1,   9, 'h00FF, 1, 'h098, 0, 0);
    step(1, 126, 'h00FF, 1, 'h7E8, 0, 0);  // delta 117
    step(1,   1, 'h00FF, 1, 'h818, 0, 0);  // counter wrap, delta 3
    step(1,   4, 'h00FF, 1, 'h848, 0, 0);
    step(1, 126, 'h00FF, 1, 'hFE8, 0, 0);  // acc 0xFE
    step(1,   3, 'h0007, 1, 'h033, 0, 0);  // delta 5, acc wraps to 0x03
    step(1,   2, 'h00FF, 1, 'h828, 0, 0);  // max delta 127
    step(1,   5, 'h00F7, 1, 'h857, 1, 0);  // bubble, popcount 7
    step(1,   8, 'hFFFF, 1, 'h88F, 0, 0);  // popcount 16 saturates to 15
    step(1,  11, 'h0000, 1, 'h8B0, 0, 0);
    step(1,  14, 'h8000, 1, 'h8E1, 1, 0);
    step(1,  14, 'h00FF, 1, 'h8E8, 0, 0);  // zero deltas start
    step(1,  14, 'h00FF, 1, 'h8E8, 0, 0);
    step(1,  14, 'h00FF, 1, 'h8E8, 0, 0);
    step(1,  14, 'h00FF, 1, 'h8E8, 0, 1);
    step(1,  14, 'h00FF, 1, 'h8E8, 0, 1);
    step(1,  17, 'h00FF, 1, 'h918, 0, 0);
    step(1,  20, 'h00FF, 1, 'h948, 0, 0);
    step(1,  23, 'h00FF, 0, 'h000, 0, 0);  // flushed by the disable below
    step(1,  26, 'h00FF, 0, 'h000, 0, 0);
    step(0,  34, 'h00FF, 0, 'h000, 0, 0);
    step(0,  42, 'h00FF, 0, 'h000, 0, 0);
    step(0,  50, 'h00FF, 0, 'h000, 0, 0);
    step(0,  58, 'h00FF, 0, 'h000, 0, 0);
    step(0,  66, 'h00FF, 0, 'h000, 0, 0);
    chk("disabled_word_hold", 32'(tdc_word), 32'h948);
    chk("disabled_valid", 32'(tdc_valid), 32'h0);
    step(1,  69, 'h00FF, 0, 'h000, 0, 0);  // re-enable through PRIME
    step(1,  72, 'h00FF, 1, 'h978, 0, 0);
    step(1,  75, 'h00F7, 1, 'h9A7, 1, 0);
    step(1,  78, 'h00FF, 0, 'h000, 0, 0);
    step(1,  81, 'h00FF, 0, 'h000, 0, 0);

    @(posedge clk);
    #7;
    chk("pre_reset_valid", 32'(tdc_valid), 32'h1);
    chk("pre_reset_bubble", 32'(bubble_err), 32'h1);
    rst_n = 1'b0;
    en    = 1'b0;
    sb.delete();
    #1;
    chk("async_reset_word", 32'(tdc_word), 32'h0);
    chk("async_reset_valid", 32'(tdc_valid), 32'h0);
    chk("async_reset_bubble", 32'(bubble_err), 32'h0);
    chk("async_reset_stall", 32'(dco_stall), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step(1,  90, 'h00FF, 0, 'h000, 0, 0);
    step(1,  93, 'h00FF, 1, 'h038, 0, 0);
    step(1,  96, 'h00FF, 1, 'h068, 0, 0);
    step(1,  99, 'h00FF, 1, 'h098, 0, 0);
    step(1, 102, 'h00FF, 0, 'h000, 0, 0);
    step(1, 105, 'h00FF, 0, 'h000, 0, 0);
    step(0, 108, 'h00FF, 0, 'h000, 0, 0);
    step(0, 108, 'h00FF, 0, 'h000, 0, 0);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
